// File: rtl/fetch_unit.sv
// Instruction-fetch / PC-sequencing stage: fetches one word per instruction over a
// req/ready handshake, holds it for the decoder, and picks the next PC on completion.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [5:0]  op_o,
   output logic [5:0]  funct_o,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        exec_done,
   input  logic        jump,
   input  logic        jr,
   input  logic        beq,
   input  logic        bne,
   input  logic        blez,
   input  logic        bgtz,
   input  logic        alu_zero,
   input  logic [31:0] rs_data,
   output logic        fetch_err,
   output logic [31:0] retired
);

   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   logic [1:0]  state;
   logic [31:0] next_pc;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        taken;

   assign pc_plus4    = pc + 32'd4;
   assign imem_req    = (state == ST_FETCH);
   assign imem_addr   = pc;
   assign instr_valid = (state == ST_EXEC);
   assign op_o        = instr[31:26];
   assign funct_o     = instr[5:0];

   assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      taken   = (beq  &  alu_zero)
              | (bne  & ~alu_zero)
              | (blez & ($signed(rs_data) <= 32'sd0))
              | (bgtz & ($signed(rs_data) >  32'sd0));
      next_pc = pc_plus4;
      if (jr)         next_pc = rs_data;
      else if (jump)  next_pc = jump_target;
      else if (taken) next_pc = branch_target;
   end

   // A misaligned target is only reachable through jr; it parks the unit in ERR
   // with pc frozen on the offending instruction for post-mortem inspection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RESET;
         pc        <= RESET_PC;
         instr     <= 32'h0;
         retired   <= 32'h0;
         fetch_err <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         case (state)
            ST_RESET: state <= ST_FETCH;
            ST_FETCH: begin
               if (imem_ready) begin
                  instr <= imem_rdata;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  retired <= retired + 32'd1;
                  if (next_pc[1:0] != 2'b00) begin
                     fetch_err <= 1'b1;
                     state     <= ST_ERR;
                  end else begin
                     pc    <= next_pc;
                     state <= ST_FETCH;
                  end
               end
            end
            ST_ERR:  state <= ST_ERR;
            default: state <= ST_ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch/exec records,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_fetch_unit;

   localparam logic [5:0] C_JR   = 6'b100000;
   localparam logic [5:0] C_J    = 6'b010000;
   localparam logic [5:0] C_BEQ  = 6'b001000;
   localparam logic [5:0] C_BNE  = 6'b000100;
   localparam logic [5:0] C_BLEZ = 6'b000010;
   localparam logic [5:0] C_BGTZ = 6'b000001;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
      logic [31:0] retired;
   } exec_rec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ready, instr_valid, exec_done;
   logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, rs_data, retired;
   logic [5:0]  op_o, funct_o;
   logic        jump, jr, beq, bne, blez, bgtz, alu_zero, fetch_err;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_pc;
   logic [31:0] m_retired;
   logic        m_err;

   logic [31:0] fetch_q[$];
   exec_rec_t   exec_q[$];

   fetch_unit #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .op_o(op_o), .funct_o(funct_o),
      .pc(pc), .pc_plus4(pc_plus4), .exec_done(exec_done),
      .jump(jump), .jr(jr), .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz),
      .alu_zero(alu_zero), .rs_data(rs_data), .fetch_err(fetch_err), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   // Reference next-PC rule, written from the architectural description.
   function automatic logic [31:0] model_next(input logic [31:0] word, input logic [31:0] cur_pc,
                                              input logic [5:0] ctrl, input logic az,
                                              input logic [31:0] rs);
      logic [31:0] seq;
      int          imm;
      bit          br;
      seq = cur_pc + 32'd4;
      imm = int'($signed(word[15:0]));
      br  = (ctrl[3] && az) || (ctrl[2] && !az) ||
            (ctrl[1] && int'(rs) <= 0) || (ctrl[0] && int'(rs) > 0);
      if (ctrl[5])      return rs;
      else if (ctrl[4]) return (seq & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
      else if (br)      return seq + 32'(imm * 4);
      else              return seq;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_req && imem_ready) begin
            if (fetch_q.size() == 0) check("unexpected_fetch", 32'd1, 32'd0);
            else check("fetch_addr", imem_addr, fetch_q.pop_front());
         end
         if (instr_valid && exec_done) begin
            if (exec_q.size() == 0) check("unexpected_exec", 32'd1, 32'd0);
            else begin
               exec_rec_t r;
               r = exec_q.pop_front();
               check("instr", instr, r.word);
               check("op_o", 32'(op_o), 32'(r.word[31:26]));
               check("funct_o", 32'(funct_o), 32'(r.word[5:0]));
               check("pc", pc, r.pc);
               check("pc_plus4", pc_plus4, r.pc + 32'd4);
               check("retired", retired, r.retired);
            end
         end
      end
   end

   task automatic drive_ctrl(input logic [5:0] ctrl, input logic az, input logic [31:0] rs);
      {jr, jump, beq, bne, blez, bgtz} = ctrl;
      alu_zero = az;
      rs_data  = rs;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req) begin
         if (n == 50) begin
            miscompares++;
            $display("FAIL fetch_timeout: imem_req never rose at %0t", $time);
            finish_run();
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   // One full instruction: optional memory wait, fetch, optional exec stall, completion.
   task automatic run_instr(input logic [31:0] word, input int nwait, input int nexec,
                            input logic [5:0] ctrl, input logic az, input logic [31:0] rs);
      exec_rec_t r;
      logic [31:0] nxt;
      wait_req();
      for (int i = 0; i < nwait; i++) begin
         imem_ready = 1'b0;
         exec_done  = 1'($urandom);
         check("wait_req", 32'(imem_req), 32'd1);
         check("wait_addr", imem_addr, m_pc);
         check("wait_valid", 32'(instr_valid), 32'd0);
         @(posedge clk); #1;
      end
      imem_ready = 1'b1;
      imem_rdata = word;
      exec_done  = 1'($urandom);
      fetch_q.push_back(m_pc);
      @(posedge clk); #1;
      check("valid_after_ready", 32'(instr_valid), 32'd1);
      imem_rdata = $urandom;
      for (int i = 0; i < nexec; i++) begin
         exec_done  = 1'b0;
         imem_ready = 1'($urandom);
         drive_ctrl(6'($urandom), 1'($urandom), $urandom);
         @(posedge clk); #1;
      end
      imem_ready = 1'($urandom);
      exec_done  = 1'b1;
      drive_ctrl(ctrl, az, rs);
      r.word = word; r.pc = m_pc; r.retired = m_retired;
      exec_q.push_back(r);
      nxt = model_next(word, m_pc, ctrl, az, rs);
      m_retired = m_retired + 32'd1;
      if (nxt[1:0] != 2'b00) m_err = 1'b1;
      else m_pc = nxt;
      @(posedge clk); #1;
      exec_done  = 1'b0;
      imem_ready = 1'b0;
      drive_ctrl(6'd0, 1'b0, 32'd0);
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_retired = 32'h0; m_err = 1'b0;
      fetch_q.delete(); exec_q.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"}, 32'(imem_req), 32'd0);
      check({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_pc"}, pc, 32'h0);
      check({tag, "_pc4"}, pc_plus4, 32'h4);
      check({tag, "_instr"}, instr, 32'h0);
      check({tag, "_op"}, 32'(op_o), 32'd0);
      check({tag, "_funct"}, 32'(funct_o), 32'd0);
      check({tag, "_retired"}, retired, 32'h0);
      check({tag, "_err"}, 32'(fetch_err), 32'd0);
   endtask

   initial begin
      #200000;
      miscompares++;
      $display("FAIL global_timeout: run did not complete");
      finish_run();
   end

   initial begin
      logic [31:0] br_word;
      logic [31:0] j_word;
      logic [5:0]  c;
      logic [31:0] rs;
      rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
      drive_ctrl(6'd0, 1'b0, 32'd0);
      model_reset();
      #13 check_reset_values("reset");
      #3 rst_n = 1'b1;

      // Sequential fetch from 0.
      for (int i = 0; i < 3; i++) run_instr($urandom, 0, 0, 6'd0, 1'b0, 32'd0);
      check("retired_after_3", retired, 32'd3);
      check("fourth_addr", imem_addr, 32'd12);
      run_instr($urandom, 3, 0, 6'd0, 1'b0, 32'd0);

      // Branches at 0x100 with imm16 = -2.
      br_word = {6'h04, 10'h0, 16'hFFFE};
      run_instr($urandom, 0, 0, C_JR, 1'b0, 32'h100);
      run_instr(br_word, 0, 1, C_BEQ, 1'b1, 32'h0);
      check("beq_target", imem_addr, 32'hFC);
      run_instr($urandom, 0, 0, C_JR, 1'b0, 32'h100);
      run_instr(br_word, 1, 0, C_BNE, 1'b1, 32'h0);
      check("bne_target", imem_addr, 32'h104);
      run_instr($urandom, 0, 0, C_JR, 1'b0, 32'h100);
      run_instr(br_word, 0, 0, C_BGTZ, 1'b0, 32'h0);
      check("bgtz_target", imem_addr, 32'h104);
      run_instr($urandom, 0, 0, C_JR, 1'b0, 32'h100);
      run_instr(br_word, 0, 2, C_BLEZ, 1'b0, 32'h8000_0000);
      check("blez_target", imem_addr, 32'hFC);

      // Jumps at 0x1000_0040.
      j_word = {6'h02, 26'h0000100};
      run_instr($urandom, 0, 0, C_JR, 1'b0, 32'h1000_0040);
      run_instr(j_word, 0, 0, C_J, 1'b0, 32'h0);
      check("jump_target", imem_addr, 32'h1000_0400);
      run_instr($urandom, 0, 0, C_JR, 1'b0, 32'h1000_0040);
      run_instr(j_word, 0, 0, C_JR, 1'b0, 32'h200);
      check("jr_target", imem_addr, 32'h200);
      run_instr(j_word, 0, 0, C_JR | C_J, 1'b0, 32'h40);
      check("jr_over_jump", imem_addr, 32'h40);

      // Randomized traffic; jr targets kept aligned so the stream keeps running.
      for (int i = 0; i < 150; i++) begin
         c  = 6'($urandom) & 6'($urandom);
         rs = $urandom;
         if (c[5]) rs[1:0] = 2'b00;
         run_instr($urandom, $urandom_range(0, 2), $urandom_range(0, 2), c, 1'($urandom), rs);
      end

      // Async reset pulse while a fetch is stalled.
      wait_req();
      imem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_req", 32'(imem_req), 32'd0);
      check("async_pc", pc, 32'h0);
      check("async_retired", retired, 32'h0);
      rst_n = 1'b1;
      model_reset();

      // Misaligned jr traps into ERR.
      run_instr($urandom, 0, 0, C_JR, 1'b0, 32'h40);
      run_instr($urandom, 0, 0, C_JR, 1'b0, 32'h202);
      imem_ready = 1'b1; exec_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("err_flag", 32'(fetch_err), 32'(m_err));
         check("err_req", 32'(imem_req), 32'd0);
         check("err_valid", 32'(instr_valid), 32'd0);
         check("err_pc", pc, m_pc);
         check("err_retired", retired, m_retired);
         @(posedge clk); #1;
      end
      imem_ready = 1'b0; exec_done = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_values("err_reset");
      check("queues_drained", 32'(fetch_q.size() + exec_q.size()), 32'd0);
      finish_run();
   end

endmodule
